mema_read_sequencer: RTL and testbench

- Controller that drives the read side of the matrix-A row memory for the row-by-vector array.
- Per memory word (row group), it steps each lane's chunk index from 1 up to that lane's multiple count, then advances to the next word.
- Emits a memory-aligned valid/last/lane-active stream for the row-by-vector modules.
- Replaces the free-running, self-restarting chunk counters with an explicit start/done job interface and a hold input for back-pressure.

---
 rtl/mema_read_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_mema_read_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mema_read_sequencer.sv
// Read-side sequencer for the matrix-A row memory of the row-by-vector array.
// Walks per-lane chunk indices per word and emits a memory-aligned beat stream.

module mema_read_sequencer #(
    parameter int NO_OF_ROW_BY_VECTOR_MODULES = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_address,
    input  logic [ADDR_WIDTH-1:0]   no_of_words,
    input  logic [CNT_WIDTH*NO_OF_ROW_BY_VECTOR_MODULES-1:0] no_of_multiples,
    input  logic                    hold,
    output logic                    busy,
    output logic [ADDR_WIDTH-1:0]   rd_address,
    output logic [CNT_WIDTH*NO_OF_ROW_BY_VECTOR_MODULES-1:0] chunk_index,
    output logic                    data_valid,
    output logic                    data_last,
    output logic                    data_word_last,
    output logic [NO_OF_ROW_BY_VECTOR_MODULES-1:0] data_lane_active,
    output logic [CNT_WIDTH*NO_OF_ROW_BY_VECTOR_MODULES-1:0] data_chunk_index,
    output logic                    done
);

    localparam int N  = NO_OF_ROW_BY_VECTOR_MODULES;
    localparam int IW = CNT_WIDTH * N;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                state;
    logic [CNT_WIDTH-1:0]  eff [N];
    logic [CNT_WIDTH-1:0]  beats_per_word;
    logic [CNT_WIDTH-1:0]  beat_cnt;
    logic [ADDR_WIDTH-1:0] words;
    logic [ADDR_WIDTH-1:0] word_cnt;

    logic [CNT_WIDTH-1:0]  eff_in [N];
    logic [CNT_WIDTH-1:0]  bpw_in;

    // A zero multiple count still occupies one beat per word.
    always_comb begin
        bpw_in = '0;
        for (int n = 0; n < N; n++) begin
            eff_in[n] = no_of_multiples[(n+1)*CNT_WIDTH-1 -: CNT_WIDTH];
            if (eff_in[n] == '0) begin
                eff_in[n] = CNT_WIDTH'(1);
            end
            if (eff_in[n] > bpw_in) begin
                bpw_in = eff_in[n];
            end
        end
    end

    logic         issue;
    logic         word_last;
    logic         last;
    logic [N-1:0] lane_active;

    assign issue     = (state == ISSUE) && !hold;
    assign word_last = (beat_cnt == beats_per_word);
    assign last      = word_last && (word_cnt == words);

    // Lanes with fewer chunks sit idle for the tail beats of the word.
    always_comb begin
        lane_active = '0;
        for (int n = 0; n < N; n++) begin
            lane_active[n] = (beat_cnt <= eff[n]);
        end
    end

    logic          p_valid [MEM_LATENCY];
    logic          p_last  [MEM_LATENCY];
    logic          p_wlast [MEM_LATENCY];
    logic [N-1:0]  p_act   [MEM_LATENCY];
    logic [IW-1:0] p_idx   [MEM_LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                p_valid[i] <= 1'b0;
                p_last[i]  <= 1'b0;
                p_wlast[i] <= 1'b0;
                p_act[i]   <= '0;
                p_idx[i]   <= '0;
            end
        end else begin
            p_valid[0] <= issue;
            p_last[0]  <= issue && last;
            p_wlast[0] <= issue && word_last;
            p_act[0]   <= issue ? lane_active : '0;
            p_idx[0]   <= chunk_index;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                p_valid[i] <= p_valid[i-1];
                p_last[i]  <= p_last[i-1];
                p_wlast[i] <= p_wlast[i-1];
                p_act[i]   <= p_act[i-1];
                p_idx[i]   <= p_idx[i-1];
            end
        end
    end

    assign data_valid       = p_valid[MEM_LATENCY-1];
    assign data_last        = p_last[MEM_LATENCY-1];
    assign data_word_last   = p_wlast[MEM_LATENCY-1];
    assign data_lane_active = p_act[MEM_LATENCY-1];
    assign data_chunk_index = p_idx[MEM_LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            rd_address     <= '0;
            chunk_index    <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            beats_per_word <= '0;
            beat_cnt       <= '0;
            words          <= '0;
            word_cnt       <= '0;
            for (int n = 0; n < N; n++) begin
                eff[n] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int n = 0; n < N; n++) begin
                            eff[n] <= eff_in[n];
                        end
                        beats_per_word <= bpw_in;
                        words          <= no_of_words;
                        if (no_of_words == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= ISSUE;
                            busy       <= 1'b1;
                            rd_address <= base_address;
                            beat_cnt   <= CNT_WIDTH'(1);
                            word_cnt   <= ADDR_WIDTH'(1);
                            for (int n = 0; n < N; n++) begin
                                chunk_index[(n+1)*CNT_WIDTH-1 -: CNT_WIDTH] <= CNT_WIDTH'(1);
                            end
                        end
                    end
                end
                ISSUE: begin
                    if (!hold) begin
                        if (word_last) begin
                            rd_address <= rd_address + ADDR_WIDTH'(1);
                            beat_cnt   <= CNT_WIDTH'(1);
                            word_cnt   <= word_cnt + ADDR_WIDTH'(1);
                            for (int n = 0; n < N; n++) begin
                                chunk_index[(n+1)*CNT_WIDTH-1 -: CNT_WIDTH] <= CNT_WIDTH'(1);
                            end
                            if (last) begin
                                state <= DRAIN;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + CNT_WIDTH'(1);
                            for (int n = 0; n < N; n++) begin
                                if (chunk_index[(n+1)*CNT_WIDTH-1 -: CNT_WIDTH] < eff[n]) begin
                                    chunk_index[(n+1)*CNT_WIDTH-1 -: CNT_WIDTH] <=
                                        chunk_index[(n+1)*CNT_WIDTH-1 -: CNT_WIDTH] + CNT_WIDTH'(1);
                                end
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (data_valid && data_last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mema_read_sequencer.sv
// Scoreboard bench for mema_read_sequencer.
// A per-job beat list model feeds a queue checked by a memory-side monitor.

module tb_mema_read_sequencer;

    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int CW  = 32;
    localparam int LAT = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           hold = 1'b0;
    logic [AW-1:0]  base_address = '0;
    logic [AW-1:0]  no_of_words = '0;
    logic [CW*N-1:0] no_of_multiples = '0;
    logic           busy;
    logic [AW-1:0]  rd_address;
    logic [CW*N-1:0] chunk_index;
    logic           data_valid;
    logic           data_last;
    logic           data_word_last;
    logic [N-1:0]   data_lane_active;
    logic [CW*N-1:0] data_chunk_index;
    logic           done;

    mema_read_sequencer #(
        .NO_OF_ROW_BY_VECTOR_MODULES(N),
        .ADDR_WIDTH(AW),
        .CNT_WIDTH(CW),
        .MEM_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .base_address(base_address),
        .no_of_words(no_of_words),
        .no_of_multiples(no_of_multiples),
        .hold(hold),
        .busy(busy),
        .rd_address(rd_address),
        .chunk_index(chunk_index),
        .data_valid(data_valid),
        .data_last(data_last),
        .data_word_last(data_word_last),
        .data_lane_active(data_lane_active),
        .data_chunk_index(data_chunk_index),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]   addr;
        logic [CW*N-1:0] idx;
        logic [N-1:0]    act;
        logic            wl;
        logic            l;
    } beat_t;

    beat_t         sb[$];
    beat_t         mon_e;
    int            checks = 0;
    int            errors = 0;
    logic [AW-1:0] addr_hist [0:LAT];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected beats straight from the job description: word by word,
    // beat b of a word carries min(b, eff) per lane and is live when b <= eff.
    task automatic push_model(input logic [AW-1:0] base, input logic [AW-1:0] words,
                              input logic [CW*N-1:0] mult, output int total);
        int unsigned eff[N];
        int unsigned bpw;
        beat_t e;
        bpw = 0;
        for (int n = 0; n < N; n++) begin
            eff[n] = mult[n*CW +: CW];
            if (eff[n] == 0) eff[n] = 1;
            if (eff[n] > bpw) bpw = eff[n];
        end
        total = int'(words) * int'(bpw);
        for (int w = 0; w < int'(words); w++) begin
            for (int unsigned b = 1; b <= bpw; b++) begin
                e.addr = base + AW'(w);
                e.idx  = '0;
                e.act  = '0;
                for (int n = 0; n < N; n++) begin
                    e.idx[n*CW +: CW] = (b < eff[n]) ? CW'(b) : CW'(eff[n]);
                    e.act[n] = (b <= eff[n]);
                end
                e.wl = (b == bpw);
                e.l  = e.wl && (w == int'(words) - 1);
                sb.push_back(e);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int i = LAT; i > 0; i--) addr_hist[i] = addr_hist[i-1];
        addr_hist[0] = rd_address;
        if (rst_n && data_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got data_valid=1 required no pending beat");
            end else begin
                mon_e = sb.pop_front();
                chk("rd_address", 128'(addr_hist[LAT]), 128'(mon_e.addr));
                chk("chunk_index", 128'(data_chunk_index), 128'(mon_e.idx));
                chk("lane_active", 128'(data_lane_active), 128'(mon_e.act));
                chk("word_last", 128'(data_word_last), 128'(mon_e.wl));
                chk("last", 128'(data_last), 128'(mon_e.l));
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_rd_address"}, 128'(rd_address), 128'(0));
        chk({tag, "_chunk_index"}, 128'(chunk_index), 128'(0));
        chk({tag, "_data_valid"}, 128'(data_valid), 128'(0));
        chk({tag, "_data_last"}, 128'(data_last), 128'(0));
        chk({tag, "_data_word_last"}, 128'(data_word_last), 128'(0));
        chk({tag, "_data_lane_active"}, 128'(data_lane_active), 128'(0));
        chk({tag, "_data_chunk_index"}, 128'(data_chunk_index), 128'(0));
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_done"}, 128'(done), 128'(0));
    endtask

    // hold_mode: 0 never, 1 random, 2 two cycles after the first issue.
    task automatic run_job(input logic [AW-1:0] base, input logic [AW-1:0] words,
                           input logic [CW*N-1:0] mult, input int hold_mode, input bit spur);
        int total;
        int c;
        int issued;
        int exp_done;
        int got;
        bit hv;
        push_model(base, words, mult, total);
        @(posedge clk); #1;
        base_address    = base;
        no_of_words     = words;
        no_of_multiples = mult;
        start           = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        c        = 1;
        issued   = 0;
        got      = -1;
        exp_done = (total == 0) ? 1 : -1;
        while (c <= 1000) begin
            hv = 1'b0;
            if (issued < total) begin
                case (hold_mode)
                    1: hv = ($urandom_range(0, 3) == 0);
                    2: hv = (c == 2 || c == 3);
                    default: hv = 1'b0;
                endcase
                if (!hv) begin
                    issued++;
                    if (issued == total) exp_done = c + LAT + 1;
                end
            end
            hold = hv;
            if (spur && (c == 3 || c == exp_done)) begin
                start           = 1'b1;
                base_address    = ~base;
                no_of_words     = words + 5;
                no_of_multiples = ~mult;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (c == 1) chk("busy_first", 128'(busy), 128'(total > 0));
            if (done) begin
                got = c;
                break;
            end
            @(posedge clk); #1;
            c++;
        end
        chk("done_cycle", 128'(got), 128'(exp_done));
        chk("busy_at_done", 128'(busy), 128'(0));
        @(posedge clk); #1;
        start = 1'b0;
        hold  = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", 128'(done), 128'(0));
        repeat (LAT + 2) @(negedge clk);
        chk("beats_left", 128'(sb.size()), 128'(0));
        chk("busy_idle", 128'(busy), 128'(0));
    endtask

    localparam logic [CW*N-1:0] BASIC_M = {32'd3, 32'd3, 32'd2, 32'd1};

    initial begin
        int total;
        logic [CW*N-1:0] m;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        run_job(32'h10, 32'd2, BASIC_M, 0, 1'b0);
        run_job(32'h40, 32'd3, '0, 0, 1'b0);
        run_job(32'h50, 32'd0, BASIC_M, 0, 1'b0);
        run_job(32'h20, 32'd1, {4{32'd2}}, 2, 1'b0);

        push_model(32'h10, 32'd2, BASIC_M, total);
        @(posedge clk); #1;
        base_address    = 32'h10;
        no_of_words     = 32'd2;
        no_of_multiples = BASIC_M;
        start           = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        sb.delete();
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_done", 128'(done), 128'(0));
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_job(32'h10, 32'd2, BASIC_M, 0, 1'b0);
        run_job(32'h10, 32'd2, BASIC_M, 0, 1'b1);
        run_job(32'hFFFF_FFFF, 32'd2, {4{32'd1}}, 0, 1'b0);

        for (int j = 0; j < 8; j++) begin
            m = '0;
            for (int n = 0; n < N; n++) m[n*CW +: CW] = CW'($urandom_range(0, 5));
            run_job($urandom, AW'($urandom_range(0, 4)), m, 1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
